// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/empty thresholds.
// Define FIFO_ERR_EN to build the sticky overflow/underflow error flags.
module fifo_param #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AF_LEVEL = DEPTH - 1,
   parameter int unsigned AE_LEVEL = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       add_fifo,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       pop_fifo,
   output logic [WIDTH-1:0]           data_out,
   output logic                       fifo_empty,
   output logic                       fifo_full,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   input  logic                       err_clr,
   output logic                       err_overflow,
   output logic                       err_underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] AF_TH = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_TH = CW'(AE_LEVEL);

   logic [CW-1:0]    wr_ptr;
   logic [CW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_en;
   logic             rd_en;

   // Status is a pure function of the registered pointers; the MSB is the wrap bit.
   assign fifo_empty   = (wr_ptr == rd_ptr);
   assign fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count        = wr_ptr - rd_ptr;
   assign almost_full  = (count >= AF_TH);
   assign almost_empty = (count <= AE_TH);

   assign wr_en = add_fifo & ~fifo_full;
   assign rd_en = pop_fifo & ~fifo_empty;

   assign data_out = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + CW'(1);
         if (rd_en) rd_ptr <= rd_ptr + CW'(1);
      end
   end

   // Storage is left unreset; data_out is gated by fifo_empty.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= data_in;
   end

`ifdef FIFO_ERR_EN
   // Sticky error flags; a set event in the same cycle as err_clr wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (add_fifo & fifo_full) err_overflow <= 1'b1;
         else if (err_clr)         err_overflow <= 1'b0;
         if (pop_fifo & fifo_empty) err_underflow <= 1'b1;
         else if (err_clr)          err_underflow <= 1'b0;
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_overflow   = 1'b0;
   assign err_underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param at default parameters.
module tb_fifo_param;

`ifdef FIFO_ERR_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        add_fifo;
   logic [15:0] data_in;
   logic        pop_fifo;
   logic [15:0] data_out;
   logic        fifo_empty;
   logic        fifo_full;
   logic        almost_full;
   logic        almost_empty;
   logic [3:0]  count;
   logic        err_clr;
   logic        err_overflow;
   logic        err_underflow;

   int checks = 0;
   int errors = 0;

   fifo_param dut (
      .clk(clk), .rst(rst), .add_fifo(add_fifo), .data_in(data_in),
      .pop_fifo(pop_fifo), .data_out(data_out), .fifo_empty(fifo_empty),
      .fifo_full(fifo_full), .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .err_clr(err_clr), .err_overflow(err_overflow),
      .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_flags(input string tag, input logic [3:0] cnt);
      check({tag, ".count"}, 32'(count), 32'(cnt));
      check({tag, ".empty"}, 32'(fifo_empty), 32'(cnt == 4'd0));
      check({tag, ".full"}, 32'(fifo_full), 32'(cnt == 4'd8));
      check({tag, ".af"}, 32'(almost_full), 32'(cnt >= 4'd7));
      check({tag, ".ae"}, 32'(almost_empty), 32'(cnt <= 4'd1));
   endtask

   initial begin
      rst = 1'b1; add_fifo = 1'b0; pop_fifo = 1'b0; err_clr = 1'b0; data_in = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      check_flags("reset", 4'd0);
      check("reset.dout", 32'(data_out), 32'h0);
      check("reset.ovf", 32'(err_overflow), 32'h0);
      check("reset.udf", 32'(err_underflow), 32'h0);

      // Fill with 1..8
      for (int i = 1; i <= 8; i++) begin
         add_fifo = 1'b1; data_in = 16'(i);
         tick();
         check_flags($sformatf("fill%0d", i), 4'(i));
         check($sformatf("fill%0d.dout", i), 32'(data_out), 32'h1);
      end
      add_fifo = 1'b0;

      // Ninth push while full
      add_fifo = 1'b1; data_in = 16'h0099;
      tick();
      add_fifo = 1'b0;
      check_flags("ovf", 4'd8);
      check("ovf.dout", 32'(data_out), 32'h1);
      check("ovf.flag", 32'(err_overflow), 32'(ERR));
      tick();
      check("ovf.hold", 32'(err_overflow), 32'(ERR));
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("ovf.clr", 32'(err_overflow), 32'h0);

      // Drain in order, then one pop on empty
      pop_fifo = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("drain%0d.dout", i), 32'(data_out), 32'(i));
         tick();
         check($sformatf("drain%0d.count", i), 32'(count), 32'(8 - i));
      end
      check_flags("drained", 4'd0);
      check("drained.dout", 32'(data_out), 32'h0);
      check("drained.udf0", 32'(err_underflow), 32'h0);
      tick();
      pop_fifo = 1'b0;
      check("udf.flag", 32'(err_underflow), 32'(ERR));
      check_flags("udf", 4'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("udf.clr", 32'(err_underflow), 32'h0);

      // Steady push+pop at count 3 across pointer wrap
      for (int i = 0; i < 3; i++) begin
         add_fifo = 1'b1; data_in = 16'(16'h10 + i);
         tick();
      end
      check_flags("c3", 4'd3);
      pop_fifo = 1'b1;
      for (int k = 0; k < 20; k++) begin
         data_in = 16'(16'h13 + k);
         check($sformatf("steady%0d.dout", k), 32'(data_out), 32'(16'h10 + k));
         tick();
         check($sformatf("steady%0d.count", k), 32'(count), 32'd3);
      end
      add_fifo = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("tail%0d.dout", k), 32'(data_out), 32'(16'h24 + k));
         tick();
      end
      pop_fifo = 1'b0;
      check_flags("tail", 4'd0);
      check("steady.udf", 32'(err_underflow), 32'h0);

      // Push+pop while full, with err_clr in the same cycle
      for (int i = 0; i < 8; i++) begin
         add_fifo = 1'b1; data_in = 16'(16'h40 + i);
         tick();
      end
      check_flags("full2", 4'd8);
      pop_fifo = 1'b1; data_in = 16'h0050; err_clr = 1'b1;
      tick();
      add_fifo = 1'b0; pop_fifo = 1'b0; err_clr = 1'b0;
      check_flags("fullpp", 4'd7);
      check("fullpp.dout", 32'(data_out), 32'h41);
      check("fullpp.ovf", 32'(err_overflow), 32'(ERR));
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("fullpp.clr", 32'(err_overflow), 32'h0);
      pop_fifo = 1'b1;
      for (int i = 1; i < 8; i++) begin
         check($sformatf("fdrain%0d.dout", i), 32'(data_out), 32'(16'h40 + i));
         tick();
      end
      pop_fifo = 1'b0;
      check_flags("fdrain", 4'd0);

      // Push+pop while empty: no bypass
      add_fifo = 1'b1; pop_fifo = 1'b1; data_in = 16'h0060;
      tick();
      add_fifo = 1'b0; pop_fifo = 1'b0;
      check_flags("emptypp", 4'd1);
      check("emptypp.dout", 32'(data_out), 32'h60);
      check("emptypp.udf", 32'(err_underflow), 32'(ERR));

      // Async reset mid-stream at count 5 (queue already holds 0x60)
      for (int i = 0; i < 4; i++) begin
         add_fifo = 1'b1; data_in = 16'(16'h70 + i);
         tick();
      end
      add_fifo = 1'b0;
      check_flags("pre_rst", 4'd5);
      #2;
      rst = 1'b1;
      #1;
      check_flags("async_rst", 4'd0);
      check("async_rst.dout", 32'(data_out), 32'h0);
      check("async_rst.udf", 32'(err_underflow), 32'h0);
      add_fifo = 1'b1; data_in = 16'h00BB;
      tick();
      add_fifo = 1'b0;
      rst = 1'b0;
      check_flags("rst_push_ignored", 4'd0);
      add_fifo = 1'b1; data_in = 16'h00AA;
      tick();
      add_fifo = 1'b0;
      check_flags("post_rst", 4'd1);
      check("post_rst.dout", 32'(data_out), 32'hAA);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
